// File: rtl/store_unit.sv
// Store unit: accepts one store, checks alignment, translates through the DTLB,
// then hands the lane-aligned store to the store buffer and reports to writeback.
module store_unit #(
  parameter int XLEN          = 64,
  parameter int PLEN          = 56,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          vaddr_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [1:0]               size_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     translation_req_o,
  output logic [XLEN-1:0]          vaddr_o,
  input  logic                     dtlb_hit_i,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     pf_exception_i,
  input  logic                     st_ready_i,
  output logic                     st_valid_o,
  output logic [PLEN-1:0]          st_paddr_o,
  output logic [XLEN-1:0]          st_data_o,
  output logic [XLEN/8-1:0]        st_be_o,
  output logic [1:0]               st_size_o,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     ex_valid_o,
  output logic [5:0]               ex_cause_o,
  output logic [XLEN-1:0]          ex_tval_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TRANS,
    WAIT_SB,
    MISALIGN
  } state_t;

  localparam logic [5:0] CAUSE_MISALIGNED = 6'd6;
  localparam logic [5:0] CAUSE_PAGE_FAULT = 6'd15;

  state_t                   state_q;
  logic [XLEN-1:0]          vaddr_q;
  logic [XLEN-1:0]          data_q;
  logic [XLEN/8-1:0]        be_q;
  logic [1:0]               size_q;
  logic [TRANS_ID_BITS-1:0] trans_id_q;
  logic [PLEN-1:0]          paddr_q;

  logic                     misaligned;
  logic [XLEN/8-1:0]        be_base;
  logic [XLEN/8-1:0]        be_next;
  logic [XLEN-1:0]          data_next;
  logic                     kill;
  logic                     hit_fault;
  logic                     hit_ok;
  logic                     direct_store;
  logic                     buffered_store;

  always_comb begin
    misaligned = 1'b0;
    be_base    = 8'h01;
    case (size_i)
      2'd0: be_base = 8'h01;
      2'd1: begin be_base = 8'h03; misaligned = vaddr_i[0];          end
      2'd2: begin be_base = 8'h0F; misaligned = |vaddr_i[1:0];       end
      default: begin be_base = 8'hFF; misaligned = |vaddr_i[2:0];    end
    endcase
  end

  assign be_next   = be_base << vaddr_i[2:0];
  assign data_next = data_i << {vaddr_i[2:0], 3'b000};

  // Reset in the same cycle must drop the store just like a flush does.
  assign kill           = flush_i | rst_i;
  assign hit_fault      = (state_q == WAIT_TRANS) && dtlb_hit_i && pf_exception_i;
  assign hit_ok         = (state_q == WAIT_TRANS) && dtlb_hit_i && !pf_exception_i;
  assign direct_store   = hit_ok && st_ready_i;
  assign buffered_store = (state_q == WAIT_SB) && st_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      vaddr_q    <= '0;
      data_q     <= '0;
      be_q       <= '0;
      size_q     <= '0;
      trans_id_q <= '0;
      paddr_q    <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            vaddr_q    <= vaddr_i;
            data_q     <= data_next;
            be_q       <= be_next;
            size_q     <= size_i;
            trans_id_q <= trans_id_i;
            state_q    <= misaligned ? MISALIGN : WAIT_TRANS;
          end
        end
        WAIT_TRANS: begin
          if (dtlb_hit_i) begin
            if (!pf_exception_i) paddr_q <= paddr_i;
            state_q <= (pf_exception_i || st_ready_i) ? IDLE : WAIT_SB;
          end
        end
        WAIT_SB: begin
          if (st_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o           = (state_q == IDLE);
  assign translation_req_o = (state_q == WAIT_TRANS) && !kill;
  assign vaddr_o           = vaddr_q;

  // On an immediate hit the store bypasses paddr_q and uses the DTLB result directly.
  assign st_valid_o = !kill && (direct_store || buffered_store);
  assign st_paddr_o = direct_store ? paddr_i : paddr_q;
  assign st_data_o  = data_q;
  assign st_be_o    = be_q;
  assign st_size_o  = size_q;

  assign ex_valid_o = !kill && ((state_q == MISALIGN) || hit_fault);
  assign valid_o    = st_valid_o || ex_valid_o;
  assign trans_id_o = trans_id_q;
  assign ex_cause_o = !ex_valid_o ? 6'd0 :
                      (state_q == MISALIGN) ? CAUSE_MISALIGNED : CAUSE_PAGE_FAULT;
  assign ex_tval_o  = ex_valid_o ? vaddr_q : '0;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: transaction-level expectations are set per
// cycle by the driver and compared against the DUT on every falling edge.
module tb_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [63:0] vaddr_i;
  logic [63:0] data_i;
  logic [1:0]  size_i;
  logic [2:0]  trans_id_i;
  logic        translation_req_o;
  logic [63:0] vaddr_o;
  logic        dtlb_hit_i;
  logic [55:0] paddr_i;
  logic        pf_exception_i;
  logic        st_ready_i;
  logic        st_valid_o;
  logic [55:0] st_paddr_o;
  logic [63:0] st_data_o;
  logic [7:0]  st_be_o;
  logic [1:0]  st_size_o;
  logic        valid_o;
  logic [2:0]  trans_id_o;
  logic        ex_valid_o;
  logic [5:0]  ex_cause_o;
  logic [63:0] ex_tval_o;

  store_unit dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .flush_i           (flush_i),
    .valid_i           (valid_i),
    .ready_o           (ready_o),
    .vaddr_i           (vaddr_i),
    .data_i            (data_i),
    .size_i            (size_i),
    .trans_id_i        (trans_id_i),
    .translation_req_o (translation_req_o),
    .vaddr_o           (vaddr_o),
    .dtlb_hit_i        (dtlb_hit_i),
    .paddr_i           (paddr_i),
    .pf_exception_i    (pf_exception_i),
    .st_ready_i        (st_ready_i),
    .st_valid_o        (st_valid_o),
    .st_paddr_o        (st_paddr_o),
    .st_data_o         (st_data_o),
    .st_be_o           (st_be_o),
    .st_size_o         (st_size_o),
    .valid_o           (valid_o),
    .trans_id_o        (trans_id_o),
    .ex_valid_o        (ex_valid_o),
    .ex_cause_o        (ex_cause_o),
    .ex_tval_o         (ex_tval_o)
  );

  always #5 clk_i = ~clk_i;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic        e_en = 1'b0;
  logic        e_ready, e_treq, e_stv, e_valid, e_exv;
  logic [63:0] e_vaddr, e_data, e_tval;
  logic [55:0] e_paddr;
  logic [7:0]  e_be;
  logic [1:0]  e_size;
  logic [2:0]  e_tid;
  logic [5:0]  e_cause;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Expected outputs only matter when their qualifying valid is expected high.
  always @(negedge clk_i) begin
    if (e_en) begin
      check_output("ready_o", 64'(ready_o), 64'(e_ready));
      check_output("translation_req_o", 64'(translation_req_o), 64'(e_treq));
      check_output("st_valid_o", 64'(st_valid_o), 64'(e_stv));
      check_output("valid_o", 64'(valid_o), 64'(e_valid));
      check_output("ex_valid_o", 64'(ex_valid_o), 64'(e_exv));
      if (e_treq) check_output("vaddr_o", vaddr_o, e_vaddr);
      if (e_stv) begin
        check_output("st_paddr_o", 64'(st_paddr_o), 64'(e_paddr));
        check_output("st_data_o", st_data_o, e_data);
        check_output("st_be_o", 64'(st_be_o), 64'(e_be));
        check_output("st_size_o", 64'(st_size_o), 64'(e_size));
      end
      if (e_valid) check_output("trans_id_o", 64'(trans_id_o), 64'(e_tid));
      if (e_exv) begin
        check_output("ex_cause_o", 64'(ex_cause_o), 64'(e_cause));
        check_output("ex_tval_o", ex_tval_o, e_tval);
      end
    end
  end

  function automatic logic [7:0] model_be(input logic [1:0] sz, input logic [2:0] off);
    int bytes = 1 << sz;
    logic [15:0] m = (16'd1 << bytes) - 16'd1;
    logic [15:0] t = m << off;
    return t[7:0];
  endfunction

  function automatic logic [63:0] model_data(input logic [63:0] d, input logic [2:0] off);
    return d << (8 * int'(off));
  endfunction

  // Advance one cycle; inputs go to quiet defaults and expectations to "busy, nothing out".
  task automatic step();
    @(posedge clk_i);
    #1;
    rst_i          = 1'b0;
    flush_i        = 1'b0;
    valid_i        = 1'b0;
    dtlb_hit_i     = 1'b0;
    st_ready_i     = 1'($urandom);
    pf_exception_i = 1'($urandom);
    paddr_i        = {$urandom, $urandom};
    vaddr_i        = {$urandom, $urandom};
    data_i         = {$urandom, $urandom};
    size_i         = 2'($urandom);
    trans_id_i     = 3'($urandom);
    e_en = 1'b1; e_ready = 1'b0; e_treq = 1'b0; e_stv = 1'b0; e_valid = 1'b0; e_exv = 1'b0;
  endtask

  task automatic idle_cycle();
    step();
    dtlb_hit_i = 1'($urandom);
    e_ready    = 1'b1;
  endtask

  task automatic expect_store(input logic [55:0] pa, input logic [63:0] d, input logic [7:0] be,
                              input logic [1:0] sz, input logic [2:0] id);
    e_stv = 1'b1; e_valid = 1'b1; e_tid = id;
    e_paddr = pa; e_data = d; e_be = be; e_size = sz;
  endtask

  task automatic expect_exc(input logic [5:0] cause, input logic [63:0] addr, input logic [2:0] id);
    e_valid = 1'b1; e_exv = 1'b1; e_cause = cause; e_tval = addr; e_tid = id;
  endtask

  // fmode: 0 none, 1 flush in WAIT_SB, 2 flush with the DTLB hit, 3 flush while awaiting DTLB.
  task automatic apply_store(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] dat,
                             input logic [2:0] id, input int tlb_delay, input logic pf,
                             input int stall, input int fmode, input logic [55:0] pa,
                             input logic [7:0] be_exp, input logic [63:0] data_exp);
    logic mis;
    mis = (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 0) || (sz == 2'd3 && addr[2:0] != 0);
    step();
    valid_i = 1'b1; vaddr_i = addr; data_i = dat; size_i = sz; trans_id_i = id;
    e_ready = 1'b1;
    if (mis) begin
      step();
      expect_exc(6'd6, addr, id);
      return;
    end
    for (int d = 0; d < tlb_delay; d++) begin
      step();
      e_treq = 1'b1; e_vaddr = addr;
      if (fmode == 3) begin
        flush_i = 1'b1; e_treq = 1'b0;
        return;
      end
    end
    step();
    dtlb_hit_i = 1'b1; paddr_i = pa; pf_exception_i = pf; st_ready_i = (stall == 0);
    if (fmode == 2) begin
      flush_i = 1'b1;
      return;
    end
    e_treq = 1'b1; e_vaddr = addr;
    if (pf) begin
      expect_exc(6'd15, addr, id);
      return;
    end
    if (stall == 0) begin
      expect_store(pa, data_exp, be_exp, sz, id);
      return;
    end
    for (int s = 1; s < stall; s++) begin
      step();
      st_ready_i = 1'b0; dtlb_hit_i = 1'($urandom);
      if (fmode == 1) begin
        flush_i = 1'b1; st_ready_i = 1'b1;
        return;
      end
    end
    step();
    st_ready_i = 1'b1; dtlb_hit_i = 1'($urandom);
    expect_store(pa, data_exp, be_exp, sz, id);
  endtask

  task automatic random_store();
    logic [1:0]  sz;
    logic [63:0] addr, dat;
    logic [55:0] pa;
    int          fmode;
    sz    = 2'($urandom);
    addr  = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
    dat   = {$urandom, $urandom};
    pa    = {$urandom, $urandom};
    fmode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
    apply_store(sz, addr, dat, 3'($urandom), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                $urandom_range(0, 3), fmode, pa, model_be(sz, addr[2:0]), model_data(dat, addr[2:0]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    step(); rst_i = 1'b1; e_en = 1'b0;
    step(); rst_i = 1'b1; e_en = 1'b0;
    idle_cycle(); dtlb_hit_i = 1'b0;
    #1;
    check_output("reset st_paddr_o", 64'(st_paddr_o), 64'd0);
    check_output("reset st_data_o", st_data_o, 64'd0);
    check_output("reset st_be_o", 64'(st_be_o), 64'd0);
    check_output("reset vaddr_o", vaddr_o, 64'd0);
    check_output("reset ex_tval_o", ex_tval_o, 64'd0);
    check_output("reset ex_cause_o", 64'(ex_cause_o), 64'd0);

    apply_store(2'd3, 64'h1008, 64'h1122334455667788, 3'd5, 0, 1'b0, 0, 0,
                56'h80001008, 8'hFF, 64'h1122334455667788);
    apply_store(2'd0, 64'h2003, 64'hAB, 3'd1, 0, 1'b0, 0, 0, 56'h80002003, 8'h08, 64'h00000000AB000000);
    apply_store(2'd1, 64'h2006, 64'hBEEF, 3'd2, 0, 1'b0, 0, 0, 56'h80002006, 8'hC0, 64'hBEEF000000000000);
    apply_store(2'd2, 64'h3002, 64'h0, 3'd3, 0, 1'b0, 0, 0, 56'h0, 8'h00, 64'h0);
    apply_store(2'd3, 64'h4000, 64'h55, 3'd4, 3, 1'b1, 0, 0, 56'h0, 8'hFF, 64'h55);
    apply_store(2'd2, 64'h5004, 64'hCAFEF00D, 3'd6, 0, 1'b0, 4, 0,
                56'h90005004, 8'hF0, 64'hCAFEF00D00000000);
    apply_store(2'd3, 64'h6000, 64'h1, 3'd7, 1, 1'b0, 3, 1, 56'h90006000, 8'hFF, 64'h1);
    apply_store(2'd3, 64'h7000, 64'h2, 3'd0, 0, 1'b0, 0, 2, 56'h90007000, 8'hFF, 64'h2);
    apply_store(2'd0, 64'h7001, 64'h77, 3'd1, 0, 1'b0, 0, 0, 56'h90007001, 8'h02, 64'h7700);

    // A request presented together with flush must not be taken.
    idle_cycle(); valid_i = 1'b1; flush_i = 1'b1;
    idle_cycle();

    // Reset while translating drops the store and clears the registered fields.
    apply_store(2'd3, 64'h8000, 64'h3, 3'd2, 2, 1'b0, 0, 3, 56'h0, 8'hFF, 64'h3);
    step(); valid_i = 1'b1; vaddr_i = 64'h9008; size_i = 2'd3; e_ready = 1'b1;
    step(); rst_i = 1'b1; dtlb_hit_i = 1'b1; pf_exception_i = 1'b0; st_ready_i = 1'b1;
    idle_cycle(); dtlb_hit_i = 1'b0;
    #1;
    check_output("post-reset st_be_o", 64'(st_be_o), 64'd0);
    check_output("post-reset st_paddr_o", 64'(st_paddr_o), 64'd0);

    for (int n = 0; n < 300; n++) begin
      random_store();
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    @(posedge clk_i);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
